seven_segment_capture: RTL and testbench
========================================

// Module: seven_segment_capture
// PURPOSE
//  Receive-side monitor for the 4-digit multiplexed 7-segment bus (active-low anodes + cathodes).
//  Samples each scanned digit once settled, decodes cathode patterns back to BCD digits and
//  rebuilds the MM:SS value as binary minutes/seconds. Sits on the board self-test path: it
//  observes the display driver's pins and reports the decoded time plus protocol errors.
// PARAMETERS
//  SETTLE_CYCLES   4        cycles anode+segments must be unchanged before a digit is sampled (>=2)
//  TIMEOUT_CYCLES  262144   cycles without a valid anode change before timeout error; frame restarts
// PORTS
//  clock          in   1  system clock
//  reset          in   1  asynchronous, active-high
//  anode_in       in   4  anode lines, active-low one-hot: 0111=d0(min tens) 1011=d1 1101=d2 1110=d3
//  segment_in     in   7  cathodes {a,b,c,d,e,f,g}, active-low
//  minutes        out  7  decoded minutes, binary 0..99
//  seconds        out  7  decoded seconds, binary 0..99
//  frame_valid    out  1  one-cycle pulse: minutes/seconds updated from a complete frame
//  pattern_error  out  1  one-cycle pulse: settled segment pattern not in digit table
//  seq_error      out  1  one-cycle pulse: digit arrived out of d0->d1->d2->d3 order
//  range_error    out  1  level, updated with frame_valid: decoded seconds > 59
//  timeout_error  out  1  one-cycle pulse: TIMEOUT_CYCLES elapsed with no new digit sampled
// BEHAVIOUR
//  - Reset: all outputs 0; FSM in WAIT_D0; digit regs, settle and timeout counters cleared.
//  - Digit table (active-low abcdefg): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100
//    5=0100100 6=0100000 7=0001111 8=0000000 9=0000100; anything else -> pattern_error.
//  - Settle: settle counter clears whenever anode_in or segment_in differs from previous cycle;
//    digit sampled exactly once, on the cycle the counter reaches SETTLE_CYCLES-1. Counter then
//    holds until the next change (no re-sample of the same dwell).
//  - Non-one-hot anode (1111 blank, or >1 low) never samples; resets settle counter, no error.
//  - FSM: WAIT_D0 -> (d0 sampled) GOT_D0 -> d1 -> GOT_D1 -> d2 -> GOT_D2 -> d3 -> COMMIT -> WAIT_D0.
//    In WAIT_D0 samples of d1..d3 are silently discarded (sync hunt).
//    In GOT_Dn a sampled digit other than d(n+1): seq_error pulse; if it is d0, store it and go
//    GOT_D0, else go WAIT_D0. Same digit re-sampled after blank dwell counts as out of order.
//  - pattern_error on any sampled digit: pulse, discard partial frame, go WAIT_D0.
//  - COMMIT (1 cycle): minutes = d0*10+d1, seconds = d2*10+d3 (7-bit, max 99, no overflow),
//    range_error = (seconds>59); frame_valid pulses same cycle outputs change. Latency: outputs
//    valid 1 clock after the d3 sample cycle (plus synchroniser delay if enabled).
//  - minutes/seconds hold last committed value between frames and on any error.
//  - Timeout counter clears on every sample; at TIMEOUT_CYCLES-1: timeout_error pulse, WAIT_D0.
//  - Simultaneous: pattern_error takes priority over seq_error; a sample in the timeout cycle
//    wins (counter clears, no timeout). Reset mid-frame discards partial frame immediately.
// CONFIGURATION
//  SEVEN_SEG_CAPTURE_SYNC_EN defined: anode_in/segment_in pass a 2-flop synchroniser (reset to
//    all-ones = blank) before settle logic; +2 cycles latency; safe for pins from another domain.
//  Undefined: inputs used directly; they must be synchronous to clock.
// STRUCTURE
//  seven_seg_pkg: SEG_0..SEG_9 pattern constants, ANODE_D0..ANODE_D3 / ANODE_BLANK codes,
//    FSM state localparams, shared with the display driver.
//  Sub-module seven_segment_pattern_decoder: combinational 7-bit pattern -> {valid, bcd[3:0]}.
// TESTING
//  1 Scan 12:34 (each digit 8 cycles, SETTLE_CYCLES=4) -> frame_valid, minutes=12, seconds=34.
//  2 Scan 59:59 then 00:00 -> two frame_valid pulses, final minutes=0, seconds=0, range_error=0.
//  3 Scan d0,d2 ordering (skip d1) -> seq_error once, no frame_valid; next clean 07:45 -> 7/45.
//  4 d1 segments=1111111 settled -> pattern_error, outputs hold prior 12/34, next frame recovers.
//  5 Segment glitch every 3 cycles on d2 -> no sample; anode static TIMEOUT_CYCLES -> timeout_error.
//  6 Scan 10:75 -> frame_valid, seconds=75, range_error=1; assert reset mid-d2 -> all outputs 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
//   Shared definitions for the 4-digit multiplexed 7-segment bus: active-low
//   cathode patterns {a,b,c,d,e,f,g} for digits 0..9, active-low anode codes
//   per digit position, capture FSM states and small helper functions.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  localparam logic [3:0] ANODE_D0    = 4'b0111;
  localparam logic [3:0] ANODE_D1    = 4'b1011;
  localparam logic [3:0] ANODE_D2    = 4'b1101;
  localparam logic [3:0] ANODE_D3    = 4'b1110;
  localparam logic [3:0] ANODE_BLANK = 4'b1111;

  typedef enum logic [2:0] {
    ST_WAIT_D0 = 3'd0,
    ST_GOT_D0  = 3'd1,
    ST_GOT_D1  = 3'd2,
    ST_GOT_D2  = 3'd3,
    ST_COMMIT  = 3'd4
  } capture_state_e;

  function automatic logic anode_is_onehot(input logic [3:0] anode);
    return (anode == ANODE_D0) || (anode == ANODE_D1) ||
           (anode == ANODE_D2) || (anode == ANODE_D3);
  endfunction

  function automatic logic [1:0] anode_position(input logic [3:0] anode);
    logic [1:0] pos;
    case (anode)
      ANODE_D1: pos = 2'd1;
      ANODE_D2: pos = 2'd2;
      ANODE_D3: pos = 2'd3;
      default:  pos = 2'd0;
    endcase
    return pos;
  endfunction

  function automatic logic [6:0] bcd_pair_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

endpackage

// File: rtl/seven_segment_pattern_decoder.sv
// seven_segment_pattern_decoder
//   Combinational decode of an active-low {a..g} cathode pattern to BCD.
//   Ports:
//     pattern  in  7  cathode pattern, active-low
//     valid    out 1  pattern is one of the ten digit glyphs
//     bcd      out 4  decoded digit (0 when not valid)
module seven_segment_pattern_decoder
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       valid,
  output logic [3:0] bcd
);

  always_comb begin
    valid = 1'b1;
    bcd   = 4'd0;
    case (pattern)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_capture.sv
// seven_segment_capture
//   Monitors a 4-digit multiplexed 7-segment bus (active-low anodes and
//   cathodes), samples each digit once it has settled, decodes it and rebuilds
//   MM:SS as binary minutes/seconds, flagging protocol errors.
//   Optional macro SEVEN_SEG_CAPTURE_SYNC_EN: inputs pass a 2-flop synchroniser
//   (reset to blank) before the settle logic, adding 2 cycles of latency.
//   Ports:
//     clock, reset (async, active-high)
//     anode_in[3:0], segment_in[6:0]   observed display pins
//     minutes[6:0], seconds[6:0]       last committed time, binary
//     frame_valid                      pulse, time updated this cycle
//     pattern_error, seq_error, timeout_error   one-cycle error pulses
//     range_error                      level, seconds > 59 on last commit
//
//   state      | meaning
//   WAIT_D0    | hunting for d0 (minutes tens); other digits discarded
//   GOT_D0     | d0 stored, expecting d1
//   GOT_D1     | d1 stored, expecting d2
//   GOT_D2     | d2 stored, expecting d3
//   COMMIT     | outputs just loaded, frame_valid high for this cycle
module seven_segment_capture
  import seven_seg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 262144
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] anode_in,
  input  logic [6:0] segment_in,
  output logic [6:0] minutes,
  output logic [6:0] seconds,
  output logic       frame_valid,
  output logic       pattern_error,
  output logic       seq_error,
  output logic       range_error,
  output logic       timeout_error
);

  localparam int SETTLE_W  = $clog2(SETTLE_CYCLES);
  localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES);

  logic [3:0] anode_s;
  logic [6:0] segment_s;

`ifdef SEVEN_SEG_CAPTURE_SYNC_EN
  logic [3:0] anode_meta, anode_sync;
  logic [6:0] segment_meta, segment_sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anode_meta   <= ANODE_BLANK;
      anode_sync   <= ANODE_BLANK;
      segment_meta <= '1;
      segment_sync <= '1;
    end else begin
      anode_meta   <= anode_in;
      anode_sync   <= anode_meta;
      segment_meta <= segment_in;
      segment_sync <= segment_meta;
    end
  end

  assign anode_s   = anode_sync;
  assign segment_s = segment_sync;
`else
  assign anode_s   = anode_in;
  assign segment_s = segment_in;
`endif

  logic [3:0]           anode_prev;
  logic [6:0]           segment_prev;
  logic [SETTLE_W-1:0]  settle_cnt;
  logic [TIMEOUT_W-1:0] timeout_cnt;
  logic                 changed, onehot, sample, timeout_hit;

  assign changed = (anode_s != anode_prev) || (segment_s != segment_prev);
  assign onehot  = anode_is_onehot(anode_s);
  // The counter reaches SETTLE_CYCLES-1 at this edge; it then saturates so a
  // long dwell produces only one sample.
  assign sample  = !changed && onehot && (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 2));
  // A sample in the terminal cycle takes precedence over the timeout.
  assign timeout_hit = !sample && (timeout_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anode_prev   <= ANODE_BLANK;
      segment_prev <= '1;
      settle_cnt   <= '0;
      timeout_cnt  <= '0;
    end else begin
      anode_prev   <= anode_s;
      segment_prev <= segment_s;
      if (changed || !onehot)
        settle_cnt <= '0;
      else if (settle_cnt != SETTLE_W'(SETTLE_CYCLES - 1))
        settle_cnt <= settle_cnt + SETTLE_W'(1);
      if (sample || timeout_hit)
        timeout_cnt <= '0;
      else
        timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
    end
  end

  logic       digit_valid;
  logic [3:0] digit_bcd;
  logic [1:0] digit_pos;

  seven_segment_pattern_decoder u_decoder (
    .pattern (segment_s),
    .valid   (digit_valid),
    .bcd     (digit_bcd)
  );

  assign digit_pos = anode_position(anode_s);

  capture_state_e state, state_next;
  logic [3:0] digit0, digit1, digit2;
  logic [1:0] expected_pos;
  logic       store0, store1, store2, load_time;
  logic       pattern_next, seq_next, timeout_next;
  logic [6:0] seconds_next;

  assign seconds_next = bcd_pair_to_bin(digit2, digit_bcd);

  always_comb begin
    state_next   = state;
    expected_pos = 2'd0;
    store0       = 1'b0;
    store1       = 1'b0;
    store2       = 1'b0;
    load_time    = 1'b0;
    pattern_next = 1'b0;
    seq_next     = 1'b0;
    timeout_next = 1'b0;

    case (state)
      ST_GOT_D0: expected_pos = 2'd1;
      ST_GOT_D1: expected_pos = 2'd2;
      ST_GOT_D2: expected_pos = 2'd3;
      default:   expected_pos = 2'd0;
    endcase

    if (sample) begin
      if (!digit_valid) begin
        pattern_next = 1'b1;
        state_next   = ST_WAIT_D0;
      end else if (digit_pos == expected_pos) begin
        case (digit_pos)
          2'd0: begin store0 = 1'b1; state_next = ST_GOT_D0; end
          2'd1: begin store1 = 1'b1; state_next = ST_GOT_D1; end
          2'd2: begin store2 = 1'b1; state_next = ST_GOT_D2; end
          default: begin load_time = 1'b1; state_next = ST_COMMIT; end
        endcase
      end else if (state == ST_WAIT_D0 || state == ST_COMMIT) begin
        state_next = ST_WAIT_D0;
      end else begin
        // Out of order; a fresh d0 restarts the frame rather than being lost.
        seq_next = 1'b1;
        if (digit_pos == 2'd0) begin
          store0     = 1'b1;
          state_next = ST_GOT_D0;
        end else begin
          state_next = ST_WAIT_D0;
        end
      end
    end else if (timeout_hit) begin
      timeout_next = 1'b1;
      state_next   = ST_WAIT_D0;
    end else if (state == ST_COMMIT) begin
      state_next = ST_WAIT_D0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_WAIT_D0;
      digit0        <= '0;
      digit1        <= '0;
      digit2        <= '0;
      minutes       <= '0;
      seconds       <= '0;
      range_error   <= 1'b0;
      pattern_error <= 1'b0;
      seq_error     <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      state         <= state_next;
      pattern_error <= pattern_next;
      seq_error     <= seq_next;
      timeout_error <= timeout_next;
      if (store0) digit0 <= digit_bcd;
      if (store1) digit1 <= digit_bcd;
      if (store2) digit2 <= digit_bcd;
      if (load_time) begin
        minutes     <= bcd_pair_to_bin(digit0, digit1);
        seconds     <= seconds_next;
        range_error <= (seconds_next > 7'd59);
      end
    end
  end

  assign frame_valid = (state == ST_COMMIT);

endmodule

// File: tb/tb_seven_segment_capture.sv
// tb_seven_segment_capture
//   Scenario tasks plus a randomized scan, checked against a behavioural
//   model of the capture rules (run-length settle, digit order, timeout).
module tb_seven_segment_capture;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 300;

  localparam logic [6:0] SEG_TABLE [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                            7'b0000000, 7'b0000100};
  localparam logic [3:0] AN_CODE [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [3:0] AN_BLANK = 4'b1111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] anode_in = 4'b1111;
  logic [6:0] segment_in = 7'b1111111;
  logic [6:0] minutes, seconds;
  logic       frame_valid, pattern_error, seq_error, range_error, timeout_error;

  int vectors = 0;
  int miscompares = 0;

  seven_segment_capture #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .anode_in      (anode_in),
    .segment_in    (segment_in),
    .minutes       (minutes),
    .seconds       (seconds),
    .frame_valid   (frame_valid),
    .pattern_error (pattern_error),
    .seq_error     (seq_error),
    .range_error   (range_error),
    .timeout_error (timeout_error)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int decode_seg(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (SEG_TABLE[i] == s) return i;
    return -1;
  endfunction

  function automatic int anode_pos(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (AN_CODE[i] == a) return i;
    return -1;
  endfunction

  // Reference model: a digit is taken on the SETTLE-th consecutive cycle of
  // an unchanged one-hot bus; frames assemble in d0..d3 order.
  logic [3:0] m_last_an;
  logic [6:0] m_last_seg;
  int m_run, m_idle, m_next, m_min, m_sec;
  int m_dig [3];
  bit m_range, e_fv, e_pe, e_se, e_te;
  int n_fv = 0, n_pe = 0, n_se = 0, n_te = 0;
  int d_fv = 0, d_pe = 0, d_se = 0, d_te = 0;

  always @(posedge clock or posedge reset) begin
    int pos, v;
    if (reset) begin
      m_last_an = AN_BLANK; m_last_seg = SEG_OFF;
      m_run = 1; m_idle = 0; m_next = 0; m_min = 0; m_sec = 0; m_range = 0;
      e_fv = 0; e_pe = 0; e_se = 0; e_te = 0;
    end else begin
      e_fv = 0; e_pe = 0; e_se = 0; e_te = 0;
      if (anode_in == m_last_an && segment_in == m_last_seg) m_run++;
      else m_run = 1;
      m_last_an = anode_in; m_last_seg = segment_in;
      pos = anode_pos(anode_in);
      if (pos >= 0 && m_run == SETTLE) begin
        m_idle = 0;
        v = decode_seg(segment_in);
        if (v < 0) begin
          e_pe = 1; m_next = 0;
        end else if (pos == m_next) begin
          if (pos == 3) begin
            m_min = m_dig[0] * 10 + m_dig[1];
            m_sec = m_dig[2] * 10 + v;
            m_range = (m_sec > 59);
            e_fv = 1; m_next = 0;
          end else begin
            m_dig[pos] = v; m_next = pos + 1;
          end
        end else if (m_next != 0) begin
          e_se = 1;
          if (pos == 0) begin m_dig[0] = v; m_next = 1; end
          else m_next = 0;
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin e_te = 1; m_idle = 0; m_next = 0; end
      end
      n_fv += int'(e_fv); n_pe += int'(e_pe); n_se += int'(e_se); n_te += int'(e_te);
    end
  end

  always @(negedge clock) begin
    if (frame_valid)   d_fv++;
    if (pattern_error) d_pe++;
    if (seq_error)     d_se++;
    if (timeout_error) d_te++;
  end

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    anode_in = an;
    segment_in = seg;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic scan(input int mm, input int ss, input int dwell);
    hold(AN_CODE[0], SEG_TABLE[mm / 10], dwell);
    hold(AN_CODE[1], SEG_TABLE[mm % 10], dwell);
    hold(AN_CODE[2], SEG_TABLE[ss / 10], dwell);
    hold(AN_CODE[3], SEG_TABLE[ss % 10], dwell);
  endtask

  task automatic test_reset();
    int te0;
    reset = 1'b1;
    hold(AN_BLANK, SEG_OFF, 3);
    vectors++;
    if ({minutes, seconds, frame_valid, pattern_error, seq_error, range_error, timeout_error} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got min=%0d sec=%0d flags=%b%b%b%b%b expected all 0", minutes, seconds,
               frame_valid, pattern_error, seq_error, range_error, timeout_error);
    end
    reset = 1'b0;
    te0 = d_te;
    hold(AN_BLANK, SEG_OFF, TIMEOUT + 5);
    vectors++;
    if (d_te - te0 !== 1 || d_te !== n_te) begin
      miscompares++;
      $display("FAIL idle_timeout: got %0d pulses (model total %0d, dut total %0d) expected 1", d_te - te0, n_te, d_te);
    end
  endtask

  task automatic test_scan_1234();
    int fv0;
    fv0 = d_fv;
    hold(AN_CODE[0], SEG_TABLE[1], 8);
    hold(AN_CODE[1], SEG_TABLE[2], 8);
    hold(AN_CODE[2], SEG_TABLE[3], 8);
    hold(AN_CODE[3], SEG_TABLE[4], 3);
    vectors++;
    if (frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL early_frame_valid: got %b expected 0", frame_valid);
    end
    hold(AN_CODE[3], SEG_TABLE[4], 1);
    vectors++;
    if (frame_valid !== 1'b1 || minutes !== 7'd12 || seconds !== 7'd34) begin
      miscompares++;
      $display("FAIL commit_1234: got fv=%b %0d:%0d expected fv=1 12:34", frame_valid, minutes, seconds);
    end
    hold(AN_CODE[3], SEG_TABLE[4], 1);
    vectors++;
    if (frame_valid !== 1'b0 || minutes !== 7'd12 || seconds !== 7'd34) begin
      miscompares++;
      $display("FAIL pulse_width_1234: got fv=%b %0d:%0d expected fv=0 12:34", frame_valid, minutes, seconds);
    end
    hold(AN_CODE[3], SEG_TABLE[4], 3);
    hold(AN_BLANK, SEG_OFF, 2);
    vectors++;
    if (d_fv - fv0 !== 1 || d_fv !== n_fv) begin
      miscompares++;
      $display("FAIL frames_1234: got %0d frames expected 1 (model total %0d dut total %0d)", d_fv - fv0, n_fv, d_fv);
    end
  endtask

  task automatic test_back_to_back();
    int fv0;
    fv0 = d_fv;
    scan(59, 59, 8);
    vectors++;
    if (minutes !== 7'd59 || seconds !== 7'd59 || range_error !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_5959: got %0d:%0d range=%b expected 59:59 range=0", minutes, seconds, range_error);
    end
    scan(0, 0, 8);
    hold(AN_BLANK, SEG_OFF, 2);
    vectors++;
    if (d_fv - fv0 !== 2 || minutes !== 7'd0 || seconds !== 7'd0 || range_error !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back: got %0d frames %0d:%0d range=%b expected 2 frames 0:0 range=0",
               d_fv - fv0, minutes, seconds, range_error);
    end
  endtask

  task automatic test_seq_error();
    int fv0, se0;
    fv0 = d_fv; se0 = d_se;
    hold(AN_CODE[0], SEG_TABLE[0], 8);
    hold(AN_CODE[2], SEG_TABLE[4], 8);
    hold(AN_CODE[3], SEG_TABLE[5], 8);
    scan(7, 45, 8);
    hold(AN_BLANK, SEG_OFF, 2);
    vectors++;
    if (d_se - se0 !== 1 || d_fv - fv0 !== 1 || minutes !== 7'd7 || seconds !== 7'd45) begin
      miscompares++;
      $display("FAIL skip_d1: got seq=%0d frames=%0d %0d:%0d expected seq=1 frames=1 7:45",
               d_se - se0, d_fv - fv0, minutes, seconds);
    end
    se0 = d_se;
    hold(AN_CODE[0], SEG_TABLE[1], 8);
    hold(AN_BLANK, SEG_OFF, 2);
    hold(AN_CODE[0], SEG_TABLE[1], 8);
    hold(AN_CODE[1], SEG_TABLE[6], 8);
    hold(AN_CODE[2], SEG_TABLE[3], 8);
    hold(AN_CODE[3], SEG_TABLE[0], 8);
    hold(AN_BLANK, SEG_OFF, 2);
    vectors++;
    if (d_se - se0 !== 1 || minutes !== 7'd16 || seconds !== 7'd30 || d_se !== n_se) begin
      miscompares++;
      $display("FAIL repeat_d0: got seq=%0d %0d:%0d expected seq=1 16:30", d_se - se0, minutes, seconds);
    end
  endtask

  task automatic test_pattern_error();
    int fv0, pe0;
    scan(12, 34, 8);
    fv0 = d_fv; pe0 = d_pe;
    hold(AN_CODE[0], SEG_TABLE[5], 8);
    hold(AN_CODE[1], SEG_OFF, 8);
    hold(AN_CODE[2], SEG_TABLE[2], 8);
    hold(AN_CODE[3], SEG_TABLE[2], 8);
    hold(AN_BLANK, SEG_OFF, 2);
    vectors++;
    if (d_pe - pe0 !== 1 || d_fv - fv0 !== 0 || minutes !== 7'd12 || seconds !== 7'd34) begin
      miscompares++;
      $display("FAIL bad_pattern: got pe=%0d frames=%0d %0d:%0d expected pe=1 frames=0 12:34",
               d_pe - pe0, d_fv - fv0, minutes, seconds);
    end
    scan(23, 58, 8);
    hold(AN_BLANK, SEG_OFF, 2);
    vectors++;
    if (minutes !== 7'd23 || seconds !== 7'd58 || d_pe !== n_pe) begin
      miscompares++;
      $display("FAIL pattern_recover: got %0d:%0d expected 23:58", minutes, seconds);
    end
  endtask

  task automatic test_timeout();
    int fv0, te0;
    fv0 = d_fv; te0 = d_te;
    hold(AN_CODE[0], SEG_TABLE[2], 8);
    hold(AN_CODE[1], SEG_TABLE[3], 8);
    for (int i = 0; i < 110; i++) hold(AN_CODE[2], SEG_TABLE[(i % 2 == 0) ? 1 : 7], 3);
    hold(AN_CODE[3], SEG_TABLE[9], 8);
    hold(AN_BLANK, SEG_OFF, 2);
    vectors++;
    if (d_te - te0 !== 1 || d_fv - fv0 !== 0 || minutes !== 7'd23 || seconds !== 7'd58 || d_te !== n_te) begin
      miscompares++;
      $display("FAIL glitch_timeout: got te=%0d frames=%0d %0d:%0d expected te=1 frames=0 23:58",
               d_te - te0, d_fv - fv0, minutes, seconds);
    end
  endtask

  task automatic test_settle_boundary();
    int fv0;
    fv0 = d_fv;
    scan(45, 12, SETTLE - 1);
    hold(AN_BLANK, SEG_OFF, 2);
    vectors++;
    if (d_fv - fv0 !== 0) begin
      miscompares++;
      $display("FAIL short_dwell: got %0d frames expected 0", d_fv - fv0);
    end
    scan(45, 12, SETTLE);
    hold(AN_BLANK, SEG_OFF, 2);
    vectors++;
    if (d_fv - fv0 !== 1 || minutes !== 7'd45 || seconds !== 7'd12) begin
      miscompares++;
      $display("FAIL exact_dwell: got frames=%0d %0d:%0d expected 1 frame 45:12", d_fv - fv0, minutes, seconds);
    end
  endtask

  task automatic test_random(input int frames);
    int mode, dwell;
    logic [3:0] an;
    logic [6:0] sg;
    logic [18:0] exp_vec;
    for (int f = 0; f < frames; f++) begin
      for (int p = 0; p < 4; p++) begin
        mode = $urandom_range(0, 19);
        dwell = $urandom_range(3, 9);
        an = AN_CODE[p];
        sg = SEG_TABLE[$urandom_range(0, 9)];
        if (mode == 0) sg = 7'($urandom);
        else if (mode == 1) an = AN_CODE[$urandom_range(0, 3)];
        else if (mode == 2) an = AN_BLANK;
        else if (mode == 3) an = 4'($urandom);
        for (int c = 0; c < dwell; c++) begin
          anode_in = an;
          segment_in = sg;
          @(posedge clock);
          @(negedge clock);
          exp_vec = {e_fv, e_pe, e_se, e_te, m_range, 7'(m_min), 7'(m_sec)};
          vectors++;
          if ({frame_valid, pattern_error, seq_error, timeout_error, range_error, minutes, seconds} !== exp_vec) begin
            miscompares++;
            $display("FAIL random_cycle: got fv/pe/se/te/re=%b%b%b%b%b %0d:%0d expected %b %0d:%0d",
                     frame_valid, pattern_error, seq_error, timeout_error, range_error, minutes, seconds,
                     exp_vec[18:14], exp_vec[13:7], exp_vec[6:0]);
          end
        end
      end
    end
  endtask

  task automatic test_range_reset();
    scan(10, 75, 8);
    vectors++;
    if (minutes !== 7'd10 || seconds !== 7'd75 || range_error !== 1'b1) begin
      miscompares++;
      $display("FAIL range_1075: got %0d:%0d range=%b expected 10:75 range=1", minutes, seconds, range_error);
    end
    hold(AN_CODE[0], SEG_TABLE[1], 8);
    hold(AN_CODE[1], SEG_TABLE[0], 8);
    hold(AN_CODE[2], SEG_TABLE[7], 5);
    reset = 1'b1;
    #1;
    vectors++;
    if ({minutes, seconds, frame_valid, pattern_error, seq_error, range_error, timeout_error} !== 19'd0) begin
      miscompares++;
      $display("FAIL async_reset: got min=%0d sec=%0d range=%b expected all 0", minutes, seconds, range_error);
    end
    hold(AN_CODE[2], SEG_TABLE[7], 2);
    reset = 1'b0;
    hold(AN_CODE[3], SEG_TABLE[5], 8);
    hold(AN_BLANK, SEG_OFF, 2);
    vectors++;
    if (minutes !== 7'd0 || seconds !== 7'd0 || range_error !== 1'b0 ||
        d_fv !== n_fv || d_pe !== n_pe || d_se !== n_se || d_te !== n_te) begin
      miscompares++;
      $display("FAIL after_reset: got %0d:%0d range=%b counts %0d/%0d/%0d/%0d expected 0:0 range=0 counts %0d/%0d/%0d/%0d",
               minutes, seconds, range_error, d_fv, d_pe, d_se, d_te, n_fv, n_pe, n_se, n_te);
    end
  endtask

  initial begin
    test_reset();
    test_scan_1234();
    test_back_to_back();
    test_seq_error();
    test_pattern_error();
    test_timeout();
    test_settle_boundary();
    test_random(120);
    test_range_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
